immgen_stage: RTL and testbench

Registered, parametrised immediate-decode stage between instruction fetch and execute. Accepts one instruction plus its PC per cycle over a valid/ready handshake and classifies its format (I/S/B/U/J/none). It sign-extends the immediate to XLEN, computes the PC-relative target, and flags illegal encodings. A two-entry skid buffer gives full throughput under backpressure, and a synchronous flush squashes in-flight entries on redirect.

---
 rtl/immgen_stage.sv | 138 +++++++++++++
 tb/tb_immgen_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/immgen_stage.sv
// Registered immediate-decode stage: classifies RV instruction formats, sign-extends the
// immediate, adds it to the PC and buffers up to two decoded entries behind a valid/ready handshake.
module immgen_stage #(
    parameter int XLEN = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Flush,
    input  logic            InValid,
    output logic            InReady,
    input  logic [31:0]     Instruction,
    input  logic [XLEN-1:0] PC,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [31:0]     InstrOut,
    output logic [XLEN-1:0] PCOut,
    output logic [XLEN-1:0] Immediate,
    output logic [2:0]      ImmFormat,
    output logic [XLEN-1:0] Target,
    output logic            Illegal
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    typedef struct packed {
        logic            valid;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] tgt;
        logic            ill;
    } entry_t;

    logic [4:0]      opcode;
    logic [2:0]      fmt_dec;
    logic            bad_opcode;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;
    entry_t          new_entry;
    entry_t          m_q, m_d;
    entry_t          s_q, s_d;
    logic            accept;
    logic            m_free;

    always_comb begin
        opcode     = Instruction[6:2];
        fmt_dec    = FMT_NONE;
        bad_opcode = 1'b0;
        case (opcode)
            5'd0, 5'd3, 5'd4, 5'd25, 5'd28: fmt_dec = FMT_I;
            5'd6:         if (XLEN == 64) fmt_dec = FMT_I; else bad_opcode = 1'b1;
            5'd8:         fmt_dec = FMT_S;
            5'd24:        fmt_dec = FMT_B;
            5'd5, 5'd13:  fmt_dec = FMT_U;
            5'd27:        fmt_dec = FMT_J;
            5'd12:        fmt_dec = FMT_NONE;
            5'd14:        if (XLEN != 64) bad_opcode = 1'b1;
            default:      bad_opcode = 1'b1;
        endcase
    end

    // Every layout keeps Instruction[31] as its MSB, so one sign extension covers all formats.
    always_comb begin
        imm32 = '0;
        case (fmt_dec)
            FMT_I: imm32 = {{20{Instruction[31]}}, Instruction[31:20]};
            FMT_S: imm32 = {{20{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
            FMT_B: imm32 = {{19{Instruction[31]}}, Instruction[31], Instruction[7],
                            Instruction[30:25], Instruction[11:8], 1'b0};
            FMT_U: imm32 = {Instruction[31:12], 12'b0};
            FMT_J: imm32 = {{11{Instruction[31]}}, Instruction[31], Instruction[19:12],
                            Instruction[20], Instruction[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_ext = XLEN'($signed(imm32));
    end

    always_comb begin
        new_entry.valid = 1'b1;
        new_entry.instr = Instruction;
        new_entry.pc    = PC;
        new_entry.imm   = imm_ext;
        new_entry.fmt   = fmt_dec;
        new_entry.tgt   = PC + imm_ext;
        new_entry.ill   = bad_opcode || (Instruction[1:0] != 2'b11);
    end

    assign InReady = !s_q.valid && !Reset;
    assign accept  = InValid && InReady;
    assign m_free  = !m_q.valid || OutReady;

    always_comb begin
        m_d = m_q;
        s_d = s_q;
        if (Flush) begin
            m_d.valid = 1'b0;
            s_d.valid = 1'b0;
        end else if (m_free) begin
            if (s_q.valid) begin
                m_d = s_q;
                if (accept) s_d = new_entry;
                else        s_d.valid = 1'b0;
            end else if (accept) begin
                m_d = new_entry;
            end else begin
                m_d.valid = 1'b0;
            end
        end else if (accept) begin
            s_d = new_entry;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            m_q <= m_d;
            s_q <= s_d;
        end
    end

    // Outputs read zero during the reset cycle itself, not only after it.
    assign OutValid  = m_q.valid && !Reset;
    assign InstrOut  = Reset ? '0 : m_q.instr;
    assign PCOut     = Reset ? '0 : m_q.pc;
    assign Immediate = Reset ? '0 : m_q.imm;
    assign ImmFormat = Reset ? '0 : m_q.fmt;
    assign Target    = Reset ? '0 : m_q.tgt;
    assign Illegal   = m_q.ill && !Reset;

endmodule

// File: tb/tb_immgen_stage.sv
// Directed bench for immgen_stage: decode vectors, backpressure ordering, flush and reset,
// with an XLEN=32 and an XLEN=64 instance fed the same stream.
module tb_immgen_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [63:0] pc64;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] instr_out32, pc_out32, imm32, tgt32;
    logic [2:0]  fmt32;

    logic        in_ready64, out_valid64, ill64;
    logic [31:0] instr_out64;
    logic [63:0] pc_out64, imm64, tgt64;
    logic [2:0]  fmt64;

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk = ~clk;
    assign pc64 = {32'b0, pc};

    immgen_stage #(.XLEN(32)) dut32 (
        .Clk(clk), .Reset(rst), .Flush(flush), .InValid(in_valid), .InReady(in_ready32),
        .Instruction(instr), .PC(pc), .OutValid(out_valid32), .OutReady(out_ready),
        .InstrOut(instr_out32), .PCOut(pc_out32), .Immediate(imm32), .ImmFormat(fmt32),
        .Target(tgt32), .Illegal(ill32)
    );

    immgen_stage #(.XLEN(64)) dut64 (
        .Clk(clk), .Reset(rst), .Flush(flush), .InValid(in_valid), .InReady(in_ready64),
        .Instruction(instr), .PC(pc64), .OutValid(out_valid64), .OutReady(out_ready),
        .InstrOut(instr_out64), .PCOut(pc_out64), .Immediate(imm64), .ImmFormat(fmt64),
        .Target(tgt64), .Illegal(ill64)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] i, input logic [31:0] p);
        in_valid = 1'b1;
        instr    = i;
        pc       = p;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = 32'hFFF00093; pc = 32'h0;
        step(); step();

        // reset state
        check_eq("rst_in_ready", in_ready32, 0);
        check_eq("rst_out_valid", out_valid32, 0);
        check_eq("rst_imm", imm32, 0);
        rst = 1'b0;
        step();

        // back-to-back ADDI, SW, LUI
        offer(32'hFFF00093, 32'h0);   step();
        check_eq("addi_valid", out_valid32, 1);
        check_eq("addi_imm", imm32, 32'hFFFFFFFF);
        check_eq("addi_fmt", fmt32, 1);
        offer(32'h00112623, 32'h4);   step();
        check_eq("sw_imm", imm32, 32'h0000000C);
        check_eq("sw_fmt", fmt32, 2);
        offer(32'h123450B7, 32'h8);   step();
        check_eq("lui_imm", imm32, 32'h12345000);
        check_eq("lui_fmt", fmt32, 4);

        // BEQ target, incl. wrap-around at PC 0
        offer(32'hFE000EE3, 32'h100); step();
        check_eq("beq_imm", imm32, 32'hFFFFFFFC);
        check_eq("beq_fmt", fmt32, 3);
        check_eq("beq_tgt", tgt32, 32'h000000FC);
        check_eq("beq_ill", ill32, 0);
        offer(32'hFE000EE3, 32'h0);   step();
        check_eq("beq_wrap_tgt", tgt32, 32'hFFFFFFFC);
        in_valid = 1'b0;              step();
        check_eq("idle_valid", out_valid32, 0);

        // backpressure: three offers, two accepted, then drain in order
        out_ready = 1'b0;
        offer(32'h00100093, 32'h10);  step();
        check_eq("bp_ready_after_1", in_ready32, 1);
        offer(32'h00200093, 32'h14);  step();
        check_eq("bp_ready_after_2", in_ready32, 0);
        offer(32'h00300093, 32'h18);  step();
        check_eq("bp_stable_pc", pc_out32, 32'h10);
        check_eq("bp_stable_imm", imm32, 32'h1);
        out_ready = 1'b1;             step();
        check_eq("bp_drain_b_pc", pc_out32, 32'h14);
        check_eq("bp_drain_b_imm", imm32, 32'h2);
        step();
        check_eq("bp_drain_c_pc", pc_out32, 32'h18);
        check_eq("bp_drain_c_valid", out_valid32, 1);
        in_valid = 1'b0;              step();
        check_eq("bp_no_dup", out_valid32, 0);

        // illegal encodings
        offer(32'h0000002F, 32'h20);  step();
        check_eq("amo_ill", ill32, 1);
        check_eq("amo_fmt", fmt32, 0);
        check_eq("amo_imm", imm32, 0);
        offer(32'hFFF00090, 32'h24);  step();
        check_eq("low00_ill", ill32, 1);
        check_eq("low00_imm", imm32, 32'hFFFFFFFF);

        // XLEN 64 vs 32
        offer(32'h800000B7, 32'h28);  step();
        check_eq("lui64_imm", imm64, 64'hFFFFFFFF80000000);
        check_eq("lui32_imm", imm32, 32'h80000000);
        offer(32'hFFF0009B, 32'h2C);  step();
        check_eq("addiw64_fmt", fmt64, 1);
        check_eq("addiw64_ill", ill64, 0);
        check_eq("addiw64_imm", imm64, 64'hFFFFFFFFFFFFFFFF);
        check_eq("addiw32_ill", ill32, 1);
        in_valid = 1'b0;              step();

        // flush with both entries full, then with an entry offered while ready
        out_ready = 1'b0;
        offer(32'h00400093, 32'h40);  step();
        offer(32'h00500093, 32'h44);  step();
        check_eq("fl_full_ready", in_ready32, 0);
        flush = 1'b1;
        offer(32'h00600093, 32'h48);  step();
        check_eq("fl_out_valid", out_valid32, 0);
        check_eq("fl_in_ready", in_ready32, 1);
        step();
        check_eq("fl_drop_valid", out_valid32, 0);
        flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; step();
        check_eq("fl_no_leak", out_valid32, 0);

        // reset mid-stream
        out_ready = 1'b0;
        offer(32'h00700093, 32'h50);  step();
        offer(32'h00800093, 32'h54);  step();
        rst = 1'b1;
        offer(32'h00900093, 32'h58);  step();
        check_eq("rs_in_ready", in_ready32, 0);
        check_eq("rs_out_valid", out_valid32, 0);
        check_eq("rs_instr", instr_out32, 0);
        check_eq("rs_pc", pc_out32, 0);
        check_eq("rs_imm", imm32, 0);
        check_eq("rs_tgt", tgt32, 0);
        rst = 1'b0; out_ready = 1'b1;
        offer(32'h00A00093, 32'h80);  step();
        check_eq("rs_first_valid", out_valid32, 1);
        check_eq("rs_first_pc", pc_out32, 32'h80);
        check_eq("rs_first_imm", imm32, 32'hA);
        in_valid = 1'b0;              step();

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
